image_store: RTL and testbench
==============================

IMAGE_STORE -- requirements
Module: image_store

Interface
REQ-001 SHALL have parameter DIM, default 64, meaning image side length in pixels; frame holds DIM*DIM pixels, row/col width 6.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port row, col  input  6 each  pixel address driven by the processing engine.
REQ-005 SHALL have port in_pix  output  24  read pixel at [row,col] of the read bank (R 23:16, G 15:8, B 7:0).
REQ-006 SHALL have port out_we  input  1  write enable from the processing engine.
REQ-007 SHALL have port out_pix  input  24  pixel written to [row,col] of the write bank.
REQ-008 SHALL have port mirror_done, gray_done, filter_done  input  1 each  stage-complete flags from the processing engine.
REQ-009 SHALL have port load_start  input  1  single-cycle request to begin a frame load.
REQ-010 SHALL have port ld_valid, ld_pix  input  1, 24  load stream handshake and pixel, raster order.
REQ-011 SHALL have port ld_ready  output  1  store accepts a load pixel.
REQ-012 SHALL have port ul_valid, ul_pix  output  1, 24  unload stream handshake and pixel, raster order.
REQ-013 SHALL have port ul_ready  input  1  sink accepts an unload pixel.
REQ-014 SHALL have port frame_ready  output  1  high while in PROC.
REQ-015 SHALL have port stage_cnt  output  2  count of stages committed in the current frame.
REQ-016 SHALL have port seq_err  output  1  sticky flag for illegal done sequencing.

Function
REQ-017 SHALL hold two banks of DIM*DIM x 24 bits, plus a 1-bit rd_bank pointer; the write bank is always the other bank (~rd_bank).
REQ-018 SHALL implement states IDLE, LOAD, PROC, UNLOAD.
REQ-019 SHALL move IDLE->LOAD on load_start; load_start in any other state is ignored.
REQ-020 SHALL drive ld_ready=1 only in LOAD; each cycle with ld_valid&&ld_ready, ld_pix is written to rd_bank at a raster address counter, which then increments.
REQ-021 SHALL, on acceptance of pixel DIM*DIM-1, go LOAD->PROC next cycle, with the address counter cleared.
REQ-022 SHALL drive in_pix combinationally as rd_bank[row][col] in every state, with zero-cycle latency from the row/col inputs.
REQ-023 SHALL, in PROC, write out_pix to write bank [row][col] at posedge when out_we=1; out_we outside PROC is ignored.
REQ-024 SHALL register each done input once and detect rising edges (done && !done_q).
REQ-025 SHALL, on a rising edge in PROC, toggle rd_bank and increment stage_cnt in the same posedge; a write in that cycle lands in the pre-toggle write bank.
REQ-026 SHALL accept only the order mirror, gray, filter; an out-of-order edge or more than one edge in the same cycle sets seq_err and causes no swap.
REQ-027 SHALL, on the filter_done commit, go PROC->UNLOAD.
REQ-028 SHALL drive ul_valid=1 in UNLOAD, with ul_pix = rd_bank[ul_addr]; ul_addr advances only on ul_valid&&ul_ready, so ul_pix stays stable while stalled.
REQ-029 SHALL, on the transfer of pixel DIM*DIM-1, go UNLOAD->IDLE, clear stage_cnt, and leave rd_bank unchanged.
REQ-030 SHALL clear seq_err only on reset or the IDLE->LOAD transition.

Reset
REQ-031 SHALL, while rst_n=0, force state IDLE, rd_bank=0, all counters 0, ld_ready=0, ul_valid=0, frame_ready=0, stage_cnt=0, seq_err=0, and done_q=0.
REQ-032 SHALL not clear memory contents on reset; a reset mid-LOAD or mid-UNLOAD abandons the transfer and requires a new load_start.

Verification
REQ-033 SHALL cover: load_start, then 4096 pixels with value = raster index -> ld_ready falls after the last accept, frame_ready=1 next cycle, in_pix at row=5,col=7 = 0x000147.
REQ-034 SHALL cover: PROC, write 0xAABBCC at [0,0], then mirror_done rise -> stage_cnt=1, in_pix at [0,0] = 0xAABBCC.
REQ-035 SHALL cover: gray_done rising before mirror_done -> seq_err=1, stage_cnt unchanged, in_pix unchanged.
REQ-036 SHALL cover: complete all three stages, then UNLOAD with ul_ready toggled every cycle -> 4096 transfers in raster order, ul_pix stable during stalls, IDLE afterwards.
REQ-037 SHALL cover: rst_n low after 100 load pixels -> ld_ready=0 immediately, state IDLE, and a new 4096-pixel load completes normally.

Source files
------------

// File: rtl/image_store.sv
// Double-banked frame store between a pixel load stream, a processing engine and an unload stream.
// Latency: in_pix/ul_pix are combinational reads; writes and all control state land on the next posedge.
// Backpressure: ld_ready is high only in LOAD; unload holds ul_pix stable until ul_ready accepts it.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   row, col, in_pix                  engine read address and combinational read of the read bank
//   out_we, out_pix                   engine write into the write bank (PROC only)
//   mirror_done, gray_done, filter_done  stage-complete flags; each rising edge commits one stage
//   load_start, ld_valid, ld_pix, ld_ready  raster-order frame load into the read bank
//   ul_valid, ul_pix, ul_ready        raster-order frame unload from the read bank
//   frame_ready, stage_cnt, seq_err   PROC indicator, committed stage count, sticky sequencing error
module image_store #(
  parameter int DIM = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  row,
  input  logic [5:0]  col,
  output logic [23:0] in_pix,
  input  logic        out_we,
  input  logic [23:0] out_pix,
  input  logic        mirror_done,
  input  logic        gray_done,
  input  logic        filter_done,
  input  logic        load_start,
  input  logic        ld_valid,
  input  logic [23:0] ld_pix,
  output logic        ld_ready,
  output logic        ul_valid,
  output logic [23:0] ul_pix,
  input  logic        ul_ready,
  output logic        frame_ready,
  output logic [1:0]  stage_cnt,
  output logic        seq_err
);

  localparam int NPIX = DIM * DIM;
  localparam int AW   = $clog2(NPIX);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PROC, UNLOAD} state_t;

  state_t        state;
  logic          rd_bank;
  logic [AW-1:0] cnt;          // shared raster counter for load and unload
  logic          mirror_q;
  logic          gray_q;
  logic          filter_q;

  // Two banks; contents deliberately survive reset.
  logic [23:0] bank0 [NPIX];
  logic [23:0] bank1 [NPIX];

  logic [AW-1:0] rc_addr;
  assign rc_addr = AW'(int'(row) * DIM + int'(col));

  assign in_pix = rd_bank ? bank1[rc_addr] : bank0[rc_addr];
  assign ul_pix = rd_bank ? bank1[cnt]     : bank0[cnt];

  // Stage sequencing: exactly one rising edge, and it must be the next stage in order.
  logic m_rise, g_rise, f_rise;
  logic any_rise, multi_rise, in_order, commit, bad_seq;

  assign m_rise     = mirror_done & ~mirror_q;
  assign g_rise     = gray_done   & ~gray_q;
  assign f_rise     = filter_done & ~filter_q;
  assign any_rise   = m_rise | g_rise | f_rise;
  assign multi_rise = (m_rise & g_rise) | (m_rise & f_rise) | (g_rise & f_rise);
  assign in_order   = ((stage_cnt == 2'd0) & m_rise) |
                      ((stage_cnt == 2'd1) & g_rise) |
                      ((stage_cnt == 2'd2) & f_rise);
  assign commit     = (state == PROC) & any_rise & ~multi_rise & in_order;
  assign bad_seq    = (state == PROC) & any_rise & ~commit;

  // Single write port: load stream targets the read bank, the engine targets the other bank.
  // A write in the swap cycle uses the pre-toggle rd_bank, so it lands in the old write bank.
  logic          wr_en;
  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_dat;

  always_comb begin
    wr_en   = 1'b0;
    wr_bank = rd_bank;
    wr_addr = cnt;
    wr_dat  = ld_pix;
    if (state == LOAD && ld_valid && ld_ready) begin
      wr_en = 1'b1;
    end else if (state == PROC && out_we) begin
      wr_en   = 1'b1;
      wr_bank = ~rd_bank;
      wr_addr = rc_addr;
      wr_dat  = out_pix;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_bank) bank1[wr_addr] <= wr_dat;
      else         bank0[wr_addr] <= wr_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rd_bank     <= 1'b0;
      cnt         <= '0;
      mirror_q    <= 1'b0;
      gray_q      <= 1'b0;
      filter_q    <= 1'b0;
      ld_ready    <= 1'b0;
      ul_valid    <= 1'b0;
      frame_ready <= 1'b0;
      stage_cnt   <= 2'd0;
      seq_err     <= 1'b0;
    end else begin
      mirror_q <= mirror_done;
      gray_q   <= gray_done;
      filter_q <= filter_done;

      case (state)
        IDLE: begin
          if (load_start) begin
            state    <= LOAD;
            ld_ready <= 1'b1;
            seq_err  <= 1'b0;
            cnt      <= '0;
          end
        end

        LOAD: begin
          if (ld_valid && ld_ready) begin
            if (cnt == LAST_ADDR) begin
              state       <= PROC;
              ld_ready    <= 1'b0;
              frame_ready <= 1'b1;
              cnt         <= '0;
            end else begin
              cnt <= cnt + AW'(1);
            end
          end
        end

        PROC: begin
          if (commit) begin
            rd_bank   <= ~rd_bank;
            stage_cnt <= stage_cnt + 2'd1;
            if (f_rise) begin
              state       <= UNLOAD;
              frame_ready <= 1'b0;
              ul_valid    <= 1'b1;
              cnt         <= '0;
            end
          end else if (bad_seq) begin
            seq_err <= 1'b1;
          end
        end

        UNLOAD: begin
          if (ul_valid && ul_ready) begin
            if (cnt == LAST_ADDR) begin
              state     <= IDLE;
              ul_valid  <= 1'b0;
              stage_cnt <= 2'd0;
              cnt       <= '0;
            end else begin
              cnt <= cnt + AW'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_store.sv
module tb_image_store;

  localparam int DIM  = 64;
  localparam int NPIX = DIM * DIM;

  logic        clk;
  logic        rst_n;
  logic [5:0]  row;
  logic [5:0]  col;
  logic [23:0] in_pix;
  logic        out_we;
  logic [23:0] out_pix;
  logic        mirror_done;
  logic        gray_done;
  logic        filter_done;
  logic        load_start;
  logic        ld_valid;
  logic [23:0] ld_pix;
  logic        ld_ready;
  logic        ul_valid;
  logic [23:0] ul_pix;
  logic        ul_ready;
  logic        frame_ready;
  logic [1:0]  stage_cnt;
  logic        seq_err;

  int checks = 0;
  int passed = 0;
  logic [23:0] exp_q [$];

  image_store #(.DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .in_pix(in_pix),
    .out_we(out_we), .out_pix(out_pix),
    .mirror_done(mirror_done), .gray_done(gray_done), .filter_done(filter_done),
    .load_start(load_start), .ld_valid(ld_valid), .ld_pix(ld_pix), .ld_ready(ld_ready),
    .ul_valid(ul_valid), .ul_pix(ul_pix), .ul_ready(ul_ready),
    .frame_ready(frame_ready), .stage_cnt(stage_cnt), .seq_err(seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] load_val(input int mode, input int i);
    logic [23:0] v;
    v = 24'(i);
    return (mode == 0) ? v : ~v;
  endfunction

  function automatic logic [23:0] filt_val(input int i);
    return 24'(i * 37 + 32'h123456);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int mode, input int npix);
    int n;
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    checks++;
    if (ld_ready !== 1'b1) $display("FAIL load_ready_rise: ld_ready=%b required 1", ld_ready);
    else passed++;
    for (int i = 0; i < npix; i++) begin
      if (i % 7 == 3) begin
        ld_valid = 1'b0;
        tick;
      end
      ld_pix   = load_val(mode, i);
      ld_valid = 1'b1;
      n = 0;
      while (ld_ready !== 1'b1 && n < 20) begin
        tick;
        n++;
      end
      if (ld_ready !== 1'b1) begin
        checks++;
        $display("FAIL load_timeout: pixel %0d ld_ready=%b required 1", i, ld_ready);
        ld_valid = 1'b0;
        return;
      end
      tick;
    end
    ld_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ld_ready !== 1'b0) $display("FAIL reset_ld_ready: got %b required 0", ld_ready); else passed++;
    checks++;
    if (ul_valid !== 1'b0) $display("FAIL reset_ul_valid: got %b required 0", ul_valid); else passed++;
    checks++;
    if (frame_ready !== 1'b0) $display("FAIL reset_frame_ready: got %b required 0", frame_ready); else passed++;
    checks++;
    if (stage_cnt !== 2'd0) $display("FAIL reset_stage_cnt: got %0d required 0", stage_cnt); else passed++;
    checks++;
    if (seq_err !== 1'b0) $display("FAIL reset_seq_err: got %b required 0", seq_err); else passed++;
    rst_n = 1'b1;
    tick;
    tick;
    checks++;
    if (ld_ready !== 1'b0) $display("FAIL idle_no_start: ld_ready=%b required 0", ld_ready); else passed++;
  endtask

  task automatic test_load;
    do_load(0, NPIX);
    checks++;
    if (ld_ready !== 1'b0) $display("FAIL load_done_ld_ready: got %b required 0", ld_ready); else passed++;
    checks++;
    if (frame_ready !== 1'b1) $display("FAIL load_done_frame_ready: got %b required 1", frame_ready); else passed++;
    checks++;
    if (stage_cnt !== 2'd0) $display("FAIL load_done_stage_cnt: got %0d required 0", stage_cnt); else passed++;
    row = 6'd5; col = 6'd7; #1;
    checks++;
    if (in_pix !== 24'h000147) $display("FAIL load_pix_5_7: got %h required 000147", in_pix); else passed++;
    row = 6'd63; col = 6'd63; #1;
    checks++;
    if (in_pix !== 24'h000FFF) $display("FAIL load_pix_63_63: got %h required 000fff", in_pix); else passed++;
    // load_start outside IDLE must not restart a load
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    tick;
    checks++;
    if (ld_ready !== 1'b0 || frame_ready !== 1'b1)
      $display("FAIL start_in_proc: ld_ready=%b frame_ready=%b required 0/1", ld_ready, frame_ready);
    else passed++;
  endtask

  task automatic test_seq_err;
    row = 6'd5; col = 6'd7;
    gray_done = 1'b1;
    tick;
    gray_done = 1'b0;
    checks++;
    if (seq_err !== 1'b1) $display("FAIL seq_err_set: got %b required 1", seq_err); else passed++;
    checks++;
    if (stage_cnt !== 2'd0) $display("FAIL seq_err_stage: got %0d required 0", stage_cnt); else passed++;
    checks++;
    if (in_pix !== 24'h000147) $display("FAIL seq_err_no_swap: got %h required 000147", in_pix); else passed++;
    tick;
  endtask

  task automatic test_mirror;
    row = 6'd0; col = 6'd0; out_pix = 24'hAABBCC; out_we = 1'b1;
    tick;
    out_we = 1'b0;
    checks++;
    if (in_pix !== 24'h000000) $display("FAIL write_other_bank: got %h required 000000", in_pix); else passed++;
    // write in the swap cycle must land in the pre-swap write bank
    row = 6'd1; col = 6'd0; out_pix = 24'h123456; out_we = 1'b1; mirror_done = 1'b1;
    tick;
    out_we = 1'b0;
    checks++;
    if (stage_cnt !== 2'd1) $display("FAIL mirror_stage: got %0d required 1", stage_cnt); else passed++;
    checks++;
    if (in_pix !== 24'h123456) $display("FAIL mirror_swap_write: got %h required 123456", in_pix); else passed++;
    row = 6'd0; #1;
    checks++;
    if (in_pix !== 24'hAABBCC) $display("FAIL mirror_pix_0_0: got %h required aabbcc", in_pix); else passed++;
    mirror_done = 1'b0;
    tick;
    checks++;
    if (stage_cnt !== 2'd1) $display("FAIL mirror_fall_no_commit: got %0d required 1", stage_cnt); else passed++;
  endtask

  task automatic test_gray;
    gray_done = 1'b1;
    tick;
    gray_done = 1'b0;
    row = 6'd5; col = 6'd7; #1;
    checks++;
    if (stage_cnt !== 2'd2) $display("FAIL gray_stage: got %0d required 2", stage_cnt); else passed++;
    checks++;
    if (in_pix !== 24'h000147) $display("FAIL gray_bank_back: got %h required 000147", in_pix); else passed++;
    tick;
  endtask

  task automatic test_filter_unload;
    int xfers;
    int cyc;
    logic [23:0] held;
    logic [23:0] e;
    logic v;
    logic rdy;
    for (int i = 0; i < NPIX; i++) begin
      row = 6'(i / DIM); col = 6'(i % DIM);
      out_pix = filt_val(i); out_we = 1'b1;
      exp_q.push_back(filt_val(i));
      tick;
    end
    out_we = 1'b0;
    filter_done = 1'b1;
    tick;
    filter_done = 1'b0;
    checks++;
    if (stage_cnt !== 2'd3) $display("FAIL filter_stage: got %0d required 3", stage_cnt); else passed++;
    checks++;
    if (ul_valid !== 1'b1 || frame_ready !== 1'b0)
      $display("FAIL unload_enter: ul_valid=%b frame_ready=%b required 1/0", ul_valid, frame_ready);
    else passed++;
    xfers = 0; cyc = 0; rdy = 1'b0;
    while (xfers < NPIX && cyc < 20000) begin
      rdy = ~rdy;
      ul_ready = rdy;
      held = ul_pix;
      v = ul_valid;
      tick;
      cyc++;
      if (v && rdy) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
        checks++;
        if (held !== e) $display("FAIL unload_pix %0d: got %h required %h", xfers, held, e);
        else passed++;
        xfers++;
      end else if (v) begin
        checks++;
        if (ul_pix !== held) $display("FAIL unload_stall_stable %0d: got %h required %h", xfers, ul_pix, held);
        else passed++;
      end
    end
    ul_ready = 1'b0;
    checks++;
    if (xfers != NPIX) $display("FAIL unload_count: got %0d required %0d", xfers, NPIX); else passed++;
    checks++;
    if (ul_valid !== 1'b0 || stage_cnt !== 2'd0 || frame_ready !== 1'b0)
      $display("FAIL unload_idle: ul_valid=%b stage_cnt=%0d frame_ready=%b required 0/0/0",
               ul_valid, stage_cnt, frame_ready);
    else passed++;
    row = 6'd0; col = 6'd0; #1;
    checks++;
    if (in_pix !== filt_val(0)) $display("FAIL idle_rd_bank_kept: got %h required %h", in_pix, filt_val(0));
    else passed++;
    row = 6'd63; col = 6'd63; #1;
    checks++;
    if (in_pix !== filt_val(NPIX - 1))
      $display("FAIL idle_last_pix: got %h required %h", in_pix, filt_val(NPIX - 1));
    else passed++;
  endtask

  task automatic test_reset_mid_load;
    do_load(1, 100);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ld_ready !== 1'b0) $display("FAIL midload_reset_ld_ready: got %b required 0", ld_ready); else passed++;
    checks++;
    if (frame_ready !== 1'b0 || ul_valid !== 1'b0 || stage_cnt !== 2'd0)
      $display("FAIL midload_reset_outs: frame_ready=%b ul_valid=%b stage_cnt=%0d required 0/0/0",
               frame_ready, ul_valid, stage_cnt);
    else passed++;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    tick;
    tick;
    checks++;
    if (ld_ready !== 1'b0) $display("FAIL midload_no_resume: ld_ready=%b required 0", ld_ready); else passed++;
    do_load(1, NPIX);
    checks++;
    if (frame_ready !== 1'b1 || ld_ready !== 1'b0)
      $display("FAIL reload_done: frame_ready=%b ld_ready=%b required 1/0", frame_ready, ld_ready);
    else passed++;
    row = 6'd5; col = 6'd7; #1;
    checks++;
    if (in_pix !== 24'hFFFEB8) $display("FAIL reload_pix_5_7: got %h required fffeb8", in_pix); else passed++;
    checks++;
    if (seq_err !== 1'b0) $display("FAIL reload_seq_err: got %b required 0", seq_err); else passed++;
    // two edges in one cycle: error, no swap
    mirror_done = 1'b1; gray_done = 1'b1;
    tick;
    mirror_done = 1'b0; gray_done = 1'b0;
    checks++;
    if (seq_err !== 1'b1 || stage_cnt !== 2'd0)
      $display("FAIL double_edge: seq_err=%b stage_cnt=%0d required 1/0", seq_err, stage_cnt);
    else passed++;
    checks++;
    if (in_pix !== 24'hFFFEB8) $display("FAIL double_edge_no_swap: got %h required fffeb8", in_pix); else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    row = '0; col = '0;
    out_we = 1'b0; out_pix = '0;
    mirror_done = 1'b0; gray_done = 1'b0; filter_done = 1'b0;
    load_start = 1'b0; ld_valid = 1'b0; ld_pix = '0;
    ul_ready = 1'b0;
    test_reset;
    test_load;
    test_seq_err;
    test_mirror;
    test_gray;
    test_filter_unload;
    test_reset_mid_load;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
